// File: rtl/uart_rx_fifo.sv
// Consumer side of the uart_rx byte handshake: buffers received bytes in a FIFO
// and re-presents them on a valid/ready stream. Optional macro UART_RX_FIFO_DROP_ERR_EN.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             rx_ack,
  input  logic             err_frame,
  input  logic             err_overrun,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] level,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic             ovf,
  input  logic             clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic          full, capture, full_stall, push, pop;

  assign full    = (level == FULL_LVL);
  assign m_valid = (level != '0);
  assign pop     = m_valid & m_ready;
  assign rd_nxt  = rd_ptr + AW'(1);

`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign push = capture & ~err_frame;
`else
  assign push = capture;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // WAIT_CLR holds off until rx_ready drops so one byte is never captured twice.
  always_comb begin
    state_nxt  = state;
    rx_ack     = 1'b0;
    capture    = 1'b0;
    full_stall = 1'b0;
    case (state)
      IDLE: begin
        if (rx_ready) begin
          if (!full) begin
            capture   = 1'b1;
            state_nxt = ACK;
          end else begin
            full_stall = 1'b1;
          end
        end
      end
      ACK: begin
        rx_ack    = 1'b1;
        state_nxt = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!rx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  // m_data is a register mirroring the head entry; a push into an empty (or
  // emptying) FIFO bypasses the array since that slot is not written yet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      m_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
      if (pop) begin
        if (level > CNT_W'(1)) m_data <= mem[rd_nxt];
        else if (push)         m_data <= rx_data;
      end else if (push && level == '0) begin
        m_data <= rx_data;
      end
    end
  end

  // A set event in the same cycle as clr takes priority over the clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err_cnt <= '0;
      ovf           <= 1'b0;
    end else begin
      if (capture && err_frame) begin
        if (clr)                          frame_err_cnt <= CNT_W'(1);
        else if (frame_err_cnt != CNT_MAX) frame_err_cnt <= frame_err_cnt + CNT_W'(1);
      end else if (clr) begin
        frame_err_cnt <= '0;
      end
      if (err_overrun || full_stall) ovf <= 1'b1;
      else if (clr)                  ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; honours UART_RX_FIFO_DROP_ERR_EN
// when computing expectations for frame-error bytes.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ack;
  logic       err_frame;
  logic       err_overrun;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] level;
  logic [4:0] frame_err_cnt;
  logic       ovf;
  logic       clr;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DEPTH(16), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_ack(rx_ack), .err_frame(err_frame), .err_overrun(err_overrun),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .frame_err_cnt(frame_err_cnt), .ovf(ovf), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behaves like uart_rx: holds rx_ready until the ack pulse, then releases it.
  task automatic send_byte(input logic [7:0] d, input logic e);
    bit seen;
    seen      = 1'b0;
    rx_data   = d;
    err_frame = e;
    rx_ready  = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (rx_ack) seen = 1'b1;
    end
    check_output("ack_seen", 32'(seen), 32'd1);
    rx_ready  = 1'b0;
    err_frame = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int acks;
    resetn = 1'b0; rx_data = '0; rx_ready = 1'b0; err_frame = 1'b0;
    err_overrun = 1'b0; m_ready = 1'b0; clr = 1'b0;
    tick();
    tick();
    check_output("rst_rx_ack", 32'(rx_ack), 32'd0);
    check_output("rst_m_valid", 32'(m_valid), 32'd0);
    check_output("rst_m_data", 32'(m_data), 32'h00);
    check_output("rst_level", 32'(level), 32'd0);
    check_output("rst_ferr", 32'(frame_err_cnt), 32'd0);
    check_output("rst_ovf", 32'(ovf), 32'd0);
    resetn = 1'b1;
    tick();

    // Single byte: ack pulse and data visible right after the capture edge
    rx_data = 8'h55; rx_ready = 1'b1;
    tick();
    check_output("t1_ack", 32'(rx_ack), 32'd1);
    check_output("t1_valid", 32'(m_valid), 32'd1);
    check_output("t1_data", 32'(m_data), 32'h55);
    rx_ready = 1'b0;
    tick();
    check_output("t1_ack_once", 32'(rx_ack), 32'd0);
    tick();
    check_output("t1_level", 32'(level), 32'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_output("t1_level_pop", 32'(level), 32'd0);
    check_output("t1_valid_pop", 32'(m_valid), 32'd0);

    // Three bytes, then drain in order
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hA3, 1'b0);
    check_output("t2_level", 32'(level), 32'd3);
    m_ready = 1'b1;
    check_output("t2_d0", 32'(m_data), 32'h12);
    tick();
    check_output("t2_d1", 32'(m_data), 32'h34);
    tick();
    check_output("t2_d2", 32'(m_data), 32'hA3);
    check_output("t2_valid2", 32'(m_valid), 32'd1);
    tick();
    check_output("t2_valid_end", 32'(m_valid), 32'd0);
    m_ready = 1'b0;

    // Fill to full, then a stalled byte sets ovf and waits for space
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    check_output("t3_full", 32'(level), 32'd16);
    check_output("t3_ovf0", 32'(ovf), 32'd0);
    rx_data = 8'h10; rx_ready = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rx_ack) acks++;
    end
    check_output("t3_no_ack", 32'(acks), 32'd0);
    check_output("t3_ovf", 32'(ovf), 32'd1);
    check_output("t3_level16", 32'(level), 32'd16);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_output("t3_level15", 32'(level), 32'd15);
    check_output("t3_no_ack_pop", 32'(rx_ack), 32'd0);
    tick();
    check_output("t3_late_ack", 32'(rx_ack), 32'd1);
    check_output("t3_refull", 32'(level), 32'd16);
    rx_ready = 1'b0;
    tick();
    tick();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check_output($sformatf("t3_drain%0d", i), 32'(m_data), 32'(i));
      tick();
    end
    m_ready = 1'b0;
    check_output("t3_empty", 32'(m_valid), 32'd0);

    // Frame-error byte, then clear and clr-vs-set priority
    send_byte(8'hC3, 1'b1);
    check_output("t4_ferr", 32'(frame_err_cnt), 32'd1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    check_output("t4_level", 32'(level), 32'd0);
    check_output("t4_valid", 32'(m_valid), 32'd0);
`else
    check_output("t4_level", 32'(level), 32'd1);
    check_output("t4_data", 32'(m_data), 32'hC3);
`endif
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_output("t4_clr_ferr", 32'(frame_err_cnt), 32'd0);
    check_output("t4_clr_ovf", 32'(ovf), 32'd0);
    clr = 1'b1; err_overrun = 1'b1;
    tick();
    err_overrun = 1'b0;
    check_output("t4_set_wins", 32'(ovf), 32'd1);
    tick();
    clr = 1'b0;
    check_output("t4_clr2", 32'(ovf), 32'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_output("t4_drained", 32'(level), 32'd0);

    // rx_ready held long after ack: exactly one capture
    rx_data = 8'h5A; rx_ready = 1'b1;
    acks = 0;
    for (int i = 0; i < 52; i++) begin
      tick();
      if (rx_ack) acks++;
    end
    check_output("t5_one_ack", 32'(acks), 32'd1);
    check_output("t5_level", 32'(level), 32'd1);
    rx_ready = 1'b0;
    tick();
    tick();
    send_byte(8'h7E, 1'b0);
    check_output("t5_level2", 32'(level), 32'd2);
    m_ready = 1'b1;
    check_output("t5_d0", 32'(m_data), 32'h5A);
    tick();
    check_output("t5_d1", 32'(m_data), 32'h7E);
    tick();
    m_ready = 1'b0;
    check_output("t5_empty", 32'(m_valid), 32'd0);

    // Asynchronous reset while level=5 and capture is parked in WAIT_CLR
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    err_overrun = 1'b1;
    tick();
    err_overrun = 1'b0;
    rx_data = 8'hA4; rx_ready = 1'b1;
    tick();
    tick();
    check_output("t6_level5", 32'(level), 32'd5);
    check_output("t6_ovf_pre", 32'(ovf), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_output("t6_rst_level", 32'(level), 32'd0);
    check_output("t6_rst_valid", 32'(m_valid), 32'd0);
    check_output("t6_rst_data", 32'(m_data), 32'h00);
    check_output("t6_rst_ovf", 32'(ovf), 32'd0);
    check_output("t6_rst_ack", 32'(rx_ack), 32'd0);
    rx_ready = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    send_byte(8'h99, 1'b0);
    check_output("t6_level", 32'(level), 32'd1);
    check_output("t6_data", 32'(m_data), 32'h99);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_output("t6_empty", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Consumer end of the uart_rx byte handshake (rx_data/rx_ready/rx_ack).
- Drains received bytes into a synchronous FIFO, pulsing rx_ack per byte. Re-presents the bytes downstream on a valid/ready stream.
- Tracks frame-error and FIFO-overflow status.
- Sits between uart_rx and the system-side byte consumer.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
CNT_W, 5, width of level and error counters; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
rx_data  input  8  byte from uart_rx, valid while rx_ready=1
rx_ready  input  1  uart_rx holds a byte
rx_ack  output  1  one-cycle pulse: byte taken
err_frame  input  1  uart_rx stop-bit error for current byte
err_overrun  input  1  uart_rx overrun indication
m_data  output  8  FIFO head byte
m_valid  output  1  FIFO non-empty
m_ready  input  1  downstream accepts m_data when m_valid&m_ready
level  output  CNT_W  current FIFO occupancy
frame_err_cnt  output  CNT_W  saturating count of bytes received with err_frame=1
ovf  output  1  sticky: rx byte waited at least one cycle on full FIFO, or err_overrun seen
clr  input  1  synchronous clear of frame_err_cnt and ovf (FIFO contents untouched)

Behaviour:
- Reset is asynchronous, active-low, applied on resetn=0.
- Reset values: rx_ack=0, m_valid=0, m_data=0, level=0, frame_err_cnt=0, ovf=0. FIFO pointers=0. Capture FSM=IDLE.
- Reset mid-byte: FIFO emptied and FSM to IDLE. A byte still flagged by rx_ready after reset is captured normally.

Capture FSM, states IDLE, ACK, WAIT_CLR:
- IDLE, rx_ready=1 and FIFO not full: write rx_data and go to ACK.
- IDLE, rx_ready=1 and FIFO full: stay in IDLE with no ack, and set ovf.
- ACK: rx_ack=1 for exactly this cycle, then WAIT_CLR.
- WAIT_CLR: stay until rx_ready=0, then IDLE. This guarantees no double capture of one byte.
- Full check in IDLE uses the current level only. A same-cycle pop does not enable a write on a full FIFO; the write happens the next cycle.
- Byte-to-m_valid latency: rx_ready seen in IDLE at cycle N → write at edge N → m_valid=1 from cycle N+1 when the FIFO was empty.

FIFO:
- Registered read port. m_data is the head entry.
- Pop when m_valid&m_ready.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from level.
- Simultaneous push and pop (not full, not empty): level unchanged, both pointers advance.
- Pop when empty: ignored. Push when full: impossible by FSM.
- m_valid=(level!=0). m_data holds stable while m_valid=1 and m_ready=0.

Status:
- frame_err_cnt increments on a captured byte with err_frame=1, saturating at 2^CNT_W-1.
- ovf sets on err_overrun=1 in any cycle, or on rx_ready held in IDLE while full.
- clr=1 zeroes frame_err_cnt and ovf. A set event in the same cycle as clr wins, so the result is count=1 or ovf=1.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_ERR_EN.
- When defined: bytes captured with err_frame=1 are acked and counted, but are not written to the FIFO. level and m_valid are unaffected by them.
- When undefined: every byte is written regardless of err_frame, and frame_err_cnt still counts.

Test Plan:
- Single byte 0x55 with rx_ready held until ack → exactly one rx_ack pulse, then m_valid=1 with m_data=0x55 one cycle after write. After the m_ready handshake: level=0, m_valid=0.
- Bytes 0x12, 0x34, 0xA3 with m_ready=0 → level=3. Then m_ready=1 → output order 0x12, 0x34, 0xA3, one per cycle, m_valid drops after the third.
- Fill 16 bytes (0x00..0x0F) with m_ready=0, then present 0x10:
  - no rx_ack, ovf=1, level=16.
  - pop one → 0x10 is acked and written on the following cycle, level=16.
  - drain order is 0x01..0x10.
- Byte 0xC3 with err_frame=1 (macro undefined) → stored, frame_err_cnt=1. With macro defined → acked, level stays 0, frame_err_cnt=1. Then clr=1 → count=0, ovf=0.
- rx_ready held high 50 cycles after ack → only one write and one rx_ack. A new byte 0x7E after rx_ready falls → second write.
- Assert resetn=0 while level=5 and FSM=WAIT_CLR → all outputs to reset values immediately. After release, a fresh byte 0x99 is captured and delivered.
